stream_mux3: RTL

Three-to-one merging multiplexer for the controller datapath: the return path for the 1-to-3 `demux` and the other end of the same `sel` encoding. It accepts 16-bit beats from three independent valid/ready sources and arbitrates between them round-robin with packet locking, so a multi-beat packet is never interleaved. It drives one registered valid/ready output tagged with the originating source.

---
 rtl/ctrl_mux_pkg.sv | 36 +++
 rtl/rr_arbiter3.sv | 34 +++
 rtl/stream_mux3.sv | 101 ++++++++++
 3 files changed

// File: rtl/ctrl_mux_pkg.sv
// Shared types for the controller datapath mux/demux pair: source tags,
// merge-mux FSM states and small index helpers.
package ctrl_mux_pkg;

   localparam int NUM_SRC = 3;

   typedef enum logic [1:0] {
      SRC_1    = 2'b00,
      SRC_2    = 2'b01,
      SRC_3    = 2'b10,
      SRC_NONE = 2'b11
   } src_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } mux_state_t;

   // Successor of a source index, wrapping 2 -> 0.
   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic logic [2:0] idx_to_onehot(input logic [1:0] s);
      logic [2:0] oh;
      oh = '0;
      case (s)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter with lock override; purely combinational.
module rr_arbiter3
   import ctrl_mux_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   input  logic       lock_en,
   input  logic [1:0] lock_src,
   output logic [2:0] grant
);

   logic [1:0] cand;
   logic       found;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant = '0;
      cand  = ptr;
      found = 1'b0;
      if (lock_en) begin
         // A locked packet owns the output even while its source bubbles.
         grant = idx_to_onehot(lock_src);
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && ((req & idx_to_onehot(cand)) != 3'b000)) begin
               grant = idx_to_onehot(cand);
               found = 1'b1;
            end
            cand = next_src(cand);
         end
      end
   end

endmodule

// File: rtl/stream_mux3.sv
// Three-to-one valid/ready merge with round-robin arbitration, packet locking
// and a single registered output stage tagged with the source index.
module stream_mux3
   import ctrl_mux_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_SRC-1:0][WIDTH-1:0]     in_data,
   input  logic [NUM_SRC-1:0]                in_valid,
   input  logic [NUM_SRC-1:0]                in_last,
   output logic [NUM_SRC-1:0]                in_ready,
   output logic [WIDTH-1:0]                  out_data,
   output logic [1:0]                        out_src,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready
);

   mux_state_t       state;
   logic [1:0]       ptr;
   logic [1:0]       lock_src;
   logic [2:0]       grant;
   logic             load_en;
   logic             xfer;
   logic [1:0]       sel_idx;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   rr_arbiter3 u_arb (
      .req      (in_valid),
      .ptr      (ptr),
      .lock_en  (state == LOCKED),
      .lock_src (lock_src),
      .grant    (grant)
   );

   assign load_en  = !out_valid || out_ready;
   // Gated by rst_n so no source sees an accept while reset is held.
   assign in_ready = (rst_n && load_en) ? grant : 3'b000;
   assign xfer     = |(in_valid & in_ready);

   always_comb begin
      sel_idx  = 2'd0;
      sel_data = in_data[0];
      sel_last = in_last[0];
      if (grant[1]) begin
         sel_idx  = 2'd1;
         sel_data = in_data[1];
         sel_last = in_last[1];
      end else if (grant[2]) begin
         sel_idx  = 2'd2;
         sel_data = in_data[2];
         sel_last = in_last[2];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= SRC_NONE;
         state     <= IDLE;
         ptr       <= 2'd0;
         lock_src  <= 2'd0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= sel_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (xfer) begin
            case (state)
               IDLE: begin
                  if (sel_last) begin
                     ptr <= next_src(sel_idx);
                  end else begin
                     lock_src <= sel_idx;
                     state    <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (sel_last) begin
                     ptr   <= next_src(lock_src);
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
